ifmap_decompressor: RTL and testbench

- Upstream neighbour of the ifmap buffer: converts the bitmap-compressed ifmap byte stream from the global buffer into dense 8-element DECOMRPESS_FIFO_PACKETs.
- The ifmap buffer pulls packets through the global_buffer_req / decompressor_ack handshake.
- Each compressed block is one mask byte followed by popcount(mask) nonzero bytes. The block expands to 8 elements, with zeros filled in at the clear mask bits.

---
 rtl/ifmap_decompressor_pkg.sv | 24 ++
 rtl/countones.sv | 19 +
 rtl/ifmap_decompressor_expand.sv | 41 ++++
 rtl/ifmap_decompressor.sv | 198 +++++++++++++++++++
 tb/tb_ifmap_decompressor.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifmap_decompressor_pkg.sv
// ifmap_decompressor_pkg
//   Shared types and constants for the bitmap ifmap decompressor.
//   - IFMP_DATA_SIZE : dense elements per output packet
//   - CMP_WORD_W     : width of one compressed input word
//   - DECOMRPESS_FIFO_PACKET : {packet_valid, valid_mask, data}
//   - decomp_state_t : IDLE / RUN / DRAIN
package ifmap_decompressor_pkg;

  localparam int IFMP_DATA_SIZE = 8;
  localparam int CMP_WORD_W     = 64;

  typedef struct packed {
    logic                                packet_valid;
    logic [IFMP_DATA_SIZE-1:0]           valid_mask;
    logic [IFMP_DATA_SIZE-1:0][7:0]      data;
  } DECOMRPESS_FIFO_PACKET;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } decomp_state_t;

endpackage

// File: rtl/countones.sv
// countones
//   Combinational population count.
//   Ports: bits [W-1:0] in, ones [CW-1:0] out = number of set bits.
module countones #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/ifmap_decompressor_expand.sv
// decomp_block_expand
//   Combinational expansion of one bitmap block.
//   Ports:
//     hdr      in  [7:0]       mask byte, bit i set = element i is nonzero
//     payload  in  [7:0][7:0]  the bytes following hdr (only the first
//                              popcount(hdr) are meaningful)
//     expanded out [7:0][7:0]  dense elements, zero where hdr bit is clear
//     need     out [3:0]       bytes occupied by the block (1 + popcount)
module decomp_block_expand
  import ifmap_decompressor_pkg::*;
(
  input  logic [IFMP_DATA_SIZE-1:0]      hdr,
  input  logic [IFMP_DATA_SIZE-1:0][7:0] payload,
  output logic [IFMP_DATA_SIZE-1:0][7:0] expanded,
  output logic [3:0]                     need
);

  logic [3:0] hdr_ones;

  countones #(.W(IFMP_DATA_SIZE)) u_hdr_pop (
    .bits (hdr),
    .ones (hdr_ones)
  );

  assign need = hdr_ones + 4'd1;

  // Payload bytes are packed in ascending element order, so element i
  // takes the payload slot equal to the number of set bits below it.
  always_comb begin
    logic [3:0] idx;
    idx      = '0;
    expanded = '0;
    for (int i = 0; i < IFMP_DATA_SIZE; i++) begin
      if (hdr[i]) begin
        expanded[i] = payload[idx[2:0]];
        idx         = idx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ifmap_decompressor.sv
// ifmap_decompressor
//   Turns the bitmap-compressed ifmap byte stream (mask byte followed by
//   popcount(mask) nonzero bytes) into dense 8-element packets pulled by
//   the ifmap buffer.
//   Ports:
//     clk, rst_n (sync, active-low)
//     start, total_elements      begin a new ifmap of N dense elements
//     cmp_data/cmp_valid/cmp_ready  compressed 64-bit words, byte 0 first
//     global_buffer_req / decompressor_ack  packet pull handshake
//     decompressed_fifo_packet   registered output packet
//     done                       pulse after the final packet is acked
//     fmt_err                    sticky: final mask has bits past the end
//   Optional (macro IFMAP_DECOMP_STATS_EN):
//     zero_fill_count            zeros inserted among valid elements
//     stall_count                cycles a packet waited for a request
module ifmap_decompressor
  import ifmap_decompressor_pkg::*;
#(
  parameter int IN_BYTES    = 8,
  parameter int STAGE_BYTES = 16,
  parameter int ELEM_CNT_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ELEM_CNT_W-1:0] total_elements,
  input  logic [CMP_WORD_W-1:0] cmp_data,
  input  logic                  cmp_valid,
  output logic                  cmp_ready,
  input  logic                  global_buffer_req,
  output logic                  decompressor_ack,
  output DECOMRPESS_FIFO_PACKET decompressed_fifo_packet,
  output logic                  done,
  output logic                  fmt_err
`ifdef IFMAP_DECOMP_STATS_EN
  ,
  output logic [ELEM_CNT_W-1:0] zero_fill_count,
  output logic [15:0]           stall_count
`endif
);

  localparam int STAGE_W = STAGE_BYTES * 8;
  localparam int CNT_W   = $clog2(STAGE_BYTES + 1);

  decomp_state_t state_reg, state_next;

  logic [STAGE_W-1:0]    stage_reg, stage_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [CNT_W-1:0]      cnt_after;
  DECOMRPESS_FIFO_PACKET pkt_reg;
  logic [ELEM_CNT_W-1:0] remaining_reg;
  logic [ELEM_CNT_W-1:0] taken;
  logic                  fmt_err_reg;
  logic                  done_reg;

  logic [IFMP_DATA_SIZE-1:0]      hdr;
  logic [IFMP_DATA_SIZE-1:0][7:0] payload;
  logic [IFMP_DATA_SIZE-1:0][7:0] expanded;
  logic [3:0]                     need;
  logic [IFMP_DATA_SIZE-1:0]      vmask;
  logic                           is_final;
  logic                           form;
  logic                           accept;
  logic                           leave_drain;

  // Block parse always looks at the head of the staging buffer.
  assign hdr     = stage_reg[7:0];
  assign payload = stage_reg[8 +: IFMP_DATA_SIZE*8];

  decomp_block_expand u_expand (
    .hdr      (hdr),
    .payload  (payload),
    .expanded (expanded),
    .need     (need)
  );

  // Element gi is valid while more than gi elements remain; this yields FF
  // for remaining >= 8 and a low-bit mask for the tail.
  genvar gi;
  generate
    for (gi = 0; gi < IFMP_DATA_SIZE; gi++) begin : g_vmask
      assign vmask[gi] = (remaining_reg > ELEM_CNT_W'(gi));
    end
  endgenerate

  assign is_final = (remaining_reg <= ELEM_CNT_W'(IFMP_DATA_SIZE));
  assign taken    = is_final ? remaining_reg : ELEM_CNT_W'(IFMP_DATA_SIZE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (form && is_final) state_next = DRAIN;
      DRAIN:   if (decompressor_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (start) state_next = RUN;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmp_ready        = (state_reg == RUN) && (count_reg <= CNT_W'(IN_BYTES));
    decompressor_ack = pkt_reg.packet_valid && global_buffer_req;
    accept           = cmp_valid && cmp_ready;
    // The output register frees up in the same cycle it is acked, which
    // gives one packet per cycle when the requester keeps pulling.
    form             = (state_reg == RUN) && (count_reg >= CNT_W'(need)) &&
                       (!pkt_reg.packet_valid || decompressor_ack);
    leave_drain      = (state_reg == DRAIN) && decompressor_ack;
    decompressed_fifo_packet = pkt_reg;
    done             = done_reg;
    fmt_err          = fmt_err_reg;
  end

  // Staging update: drop the consumed block from the head, then append the
  // accepted word right after the surviving bytes. Bytes at and above
  // count_reg are kept zero so the OR-append is safe.
  always_comb begin
    logic [STAGE_W-1:0] shifted;
    logic [STAGE_W-1:0] appended;
    cnt_after  = count_reg - (form ? CNT_W'(need) : CNT_W'(0));
    shifted    = form ? (stage_reg >> {need, 3'b000}) : stage_reg;
    appended   = {{(STAGE_W-CMP_WORD_W){1'b0}}, cmp_data} << {cnt_after, 3'b000};
    stage_next = accept ? (shifted | appended) : shifted;
    count_next = cnt_after + (accept ? CNT_W'(IN_BYTES) : CNT_W'(0));
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg     <= '0;
      count_reg     <= '0;
      pkt_reg       <= '0;
      remaining_reg <= '0;
      fmt_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else if (start) begin
      stage_reg     <= '0;
      count_reg     <= '0;
      pkt_reg       <= '0;
      remaining_reg <= total_elements;
      fmt_err_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Word padding left after the final block is thrown away here.
      if (leave_drain) begin
        stage_reg <= '0;
        count_reg <= '0;
      end else begin
        stage_reg <= stage_next;
        count_reg <= count_next;
      end
      if (form) begin
        pkt_reg.packet_valid <= 1'b1;
        pkt_reg.valid_mask   <= vmask;
        pkt_reg.data         <= expanded;
        remaining_reg        <= remaining_reg - taken;
        if (is_final && |(hdr & ~vmask)) fmt_err_reg <= 1'b1;
      end else if (decompressor_ack) begin
        pkt_reg <= '0;
      end
      done_reg <= leave_drain;
    end
  end

`ifdef IFMAP_DECOMP_STATS_EN
  logic [3:0]            zf_ones;
  logic [ELEM_CNT_W-1:0] zero_fill_reg;
  logic [15:0]           stall_reg;

  countones #(.W(IFMP_DATA_SIZE)) u_zf_pop (
    .bits (vmask & ~hdr),
    .ones (zf_ones)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      zero_fill_reg <= '0;
      stall_reg     <= '0;
    end else begin
      if (form) zero_fill_reg <= zero_fill_reg + ELEM_CNT_W'(zf_ones);
      if (pkt_reg.packet_valid && !global_buffer_req && (stall_reg != 16'hFFFF))
        stall_reg <= stall_reg + 16'd1;
    end
  end

  assign zero_fill_count = zero_fill_reg;
  assign stall_count     = stall_reg;
`endif

endmodule

// File: tb/tb_ifmap_decompressor.sv
`timescale 1ns/1ps
module tb_ifmap_decompressor;
  import ifmap_decompressor_pkg::*;

  localparam int ELEM_CNT_W = 20;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ELEM_CNT_W-1:0] total_elements = '0;
  logic [63:0]           cmp_data = '0;
  logic                  cmp_valid = 1'b0;
  logic                  cmp_ready;
  logic                  global_buffer_req = 1'b0;
  logic                  decompressor_ack;
  DECOMRPESS_FIFO_PACKET pkt;
  logic                  done;
  logic                  fmt_err;
`ifdef IFMAP_DECOMP_STATS_EN
  logic [ELEM_CNT_W-1:0] zero_fill_count;
  logic [15:0]           stall_count;
`endif

  ifmap_decompressor #(.ELEM_CNT_W(ELEM_CNT_W)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .total_elements           (total_elements),
    .cmp_data                 (cmp_data),
    .cmp_valid                (cmp_valid),
    .cmp_ready                (cmp_ready),
    .global_buffer_req        (global_buffer_req),
    .decompressor_ack         (decompressor_ack),
    .decompressed_fifo_packet (pkt),
    .done                     (done),
    .fmt_err                  (fmt_err)
`ifdef IFMAP_DECOMP_STATS_EN
    ,
    .zero_fill_count          (zero_fill_count),
    .stall_count              (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- passive monitor ----------------
  DECOMRPESS_FIFO_PACKET got_q[$];
  int unsigned           ack_cyc_q[$];
  int unsigned           hs_cyc_q[$];
  logic                  rdy_after_q[$];
  logic                  hs_prev = 1'b0;
  logic [7:0]            stream_q[$];

  always @(negedge clk) begin
    if (hs_prev) rdy_after_q.push_back(cmp_ready);
    hs_prev = cmp_valid && cmp_ready;
    if (cmp_valid && cmp_ready) hs_cyc_q.push_back(cyc);
    if (decompressor_ack) begin
      got_q.push_back(pkt);
      ack_cyc_q.push_back(cyc);
      $display("pkt cyc=%0d mask=%02h data=%016h", cyc, pkt.valid_mask, pkt.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic DECOMRPESS_FIFO_PACKET mkp(input logic [7:0] m, input logic [63:0] d);
    DECOMRPESS_FIFO_PACKET p;
    p.packet_valid = 1'b1;
    p.valid_mask   = m;
    p.data         = d;
    return p;
  endfunction

  task automatic chk_pkt(input string tag, input int idx, input DECOMRPESS_FIFO_PACKET exp);
    DECOMRPESS_FIFO_PACKET g;
    g = '0;
    if (idx < got_q.size()) g = got_q[idx];
    chk(tag, g, exp);
  endtask

  task automatic clear_q();
    got_q.delete();
    ack_cyc_q.delete();
    hs_cyc_q.delete();
    rdy_after_q.delete();
    stream_q.delete();
  endtask

  // All driving tasks are entered and left at posedge + 1.
  task automatic do_start(input logic [ELEM_CNT_W-1:0] tot);
    start = 1'b1;
    total_elements = tot;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    int n;
    n = 0;
    cmp_data  = w;
    cmp_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (cmp_ready) break;
      n++;
      if (n > 50) begin
        chk("word_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_stream();
    int nw;
    nw = (stream_q.size() + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      logic [63:0] word;
      word = '0;
      for (int k = 0; k < 8; k++)
        if (w*8 + k < stream_q.size()) word[8*k +: 8] = stream_q[w*8 + k];
      send_word(word);
    end
    cmp_valid = 1'b0;
  endtask

  task automatic push_block(input logic [7:0] h, input logic [7:0] base, input int n);
    stream_q.push_back(h);
    for (int k = 0; k < n; k++) stream_q.push_back(base + 8'(k));
  endtask

  task automatic wait_done(input string tag);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk(tag, seen, 1);
    @(negedge clk);
    chk({tag, "_1cyc"}, done, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    global_buffer_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmp_ready, 0);
    chk("rst_pvalid", pkt.packet_valid, 0);
    chk("rst_ack", decompressor_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_fmt", fmt_err, 0);
    @(posedge clk); #1;

    // Basic expand: 05,11,22 -> elements 0 and 2
    clear_q();
    do_start(8);
    stream_q.push_back(8'h05); stream_q.push_back(8'h11); stream_q.push_back(8'h22);
    send_stream();
    wait_done("basic_done");
    chk("basic_npkt", got_q.size(), 1);
    chk_pkt("basic_pkt", 0, mkp(8'hFF, 64'h0000_0000_0022_0011));
    chk("basic_lat", (ack_cyc_q.size() > 0 && hs_cyc_q.size() > 0) ?
        ack_cyc_q[0] - hs_cyc_q[0] : 0, 2);

    // Straddle: three full blocks spread over four words
    clear_q();
    do_start(24);
    push_block(8'hFF, 8'h01, 8);
    push_block(8'hFF, 8'h11, 8);
    push_block(8'hFF, 8'h21, 8);
    send_stream();
    wait_done("strad_done");
    chk("strad_npkt", got_q.size(), 3);
    chk_pkt("strad_p0", 0, mkp(8'hFF, 64'h0807_0605_0403_0201));
    chk_pkt("strad_p1", 1, mkp(8'hFF, 64'h1817_1615_1413_1211));
    chk_pkt("strad_p2", 2, mkp(8'hFF, 64'h2827_2625_2423_2221));
    chk("strad_rdy0", rdy_after_q.size() > 0 ? rdy_after_q[0] : 1'bx, 1);
    chk("strad_rdy1", rdy_after_q.size() > 1 ? rdy_after_q[1] : 1'bx, 0);
    chk("strad_rdy2", rdy_after_q.size() > 2 ? rdy_after_q[2] : 1'bx, 0);
    chk("strad_rdy3", rdy_after_q.size() > 3 ? rdy_after_q[3] : 1'bx, 0);

    // Tail with a well-formed final block
    clear_q();
    do_start(13);
    push_block(8'hFF, 8'h01, 8);
    push_block(8'h1F, 8'h11, 5);
    send_stream();
    wait_done("tail_done");
    chk_pkt("tail_p0", 0, mkp(8'hFF, 64'h0807_0605_0403_0201));
    chk_pkt("tail_p1", 1, mkp(8'h1F, 64'h0000_0015_1413_1211));
    chk("tail_fmt", fmt_err, 0);

    // Tail with a mask bit beyond the end
    clear_q();
    do_start(13);
    push_block(8'hFF, 8'h01, 8);
    push_block(8'h3F, 8'h21, 6);
    send_stream();
    wait_done("tailerr_done");
    chk_pkt("tailerr_p1", 1, mkp(8'h1F, 64'h0000_2625_2423_2221));
    chk("tailerr_fmt", fmt_err, 1);
    @(negedge clk);
    chk("tailerr_sticky", fmt_err, 1);
    @(posedge clk); #1;

    // Restart mid-RUN after one packet
    clear_q();
    do_start(16);
    chk("restart_fmtclr", fmt_err, 0);
    push_block(8'hFF, 8'h01, 8);
    push_block(8'hFF, 8'h11, 6);
    send_stream();
    begin
      int n;
      n = 0;
      while (got_q.size() < 1 && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      chk("restart_first", got_q.size(), 1);
    end
    do_start(8);
    chk("restart_flush", pkt.packet_valid, 0);
    stream_q.delete();
    stream_q.push_back(8'h03); stream_q.push_back(8'h77); stream_q.push_back(8'h88);
    send_stream();
    wait_done("restart_done");
    chk("restart_npkt", got_q.size(), 2);
    chk_pkt("restart_p1", 1, mkp(8'hFF, 64'h0000_0000_0000_8877));

    // Backpressure: req 1,0,0,1 once packets flow
    clear_q();
    global_buffer_req = 1'b0;
    do_start(16);
    push_block(8'h01, 8'hAA, 1);
    push_block(8'h01, 8'hBB, 1);
    send_stream();
    @(posedge clk); #1; global_buffer_req = 1'b1;
    @(posedge clk); #1; global_buffer_req = 1'b0;
    @(negedge clk);
    chk("bp_hold1", pkt, mkp(8'hFF, 64'h0000_0000_0000_00BB));
    chk("bp_noack1", decompressor_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_hold2", pkt, mkp(8'hFF, 64'h0000_0000_0000_00BB));
    chk("bp_noack2", decompressor_ack, 0);
    @(posedge clk); #1; global_buffer_req = 1'b1;
    wait_done("bp_done");
    chk("bp_npkt", got_q.size(), 2);
    chk_pkt("bp_p0", 0, mkp(8'hFF, 64'h0000_0000_0000_00AA));
    chk_pkt("bp_p1", 1, mkp(8'hFF, 64'h0000_0000_0000_00BB));
`ifdef IFMAP_DECOMP_STATS_EN
    chk("bp_stall", stall_count, 2);
`endif

    // All-zero blocks: one byte per packet, back to back
    clear_q();
    do_start(32);
    for (int k = 0; k < 4; k++) stream_q.push_back(8'h00);
    send_stream();
    wait_done("zero_done");
    chk("zero_npkt", got_q.size(), 4);
    for (int k = 0; k < 4; k++) chk_pkt($sformatf("zero_p%0d", k), k, mkp(8'hFF, 64'h0));
    chk("zero_b2b", ack_cyc_q.size() == 4 ? ack_cyc_q[3] - ack_cyc_q[0] : 0, 3);
`ifdef IFMAP_DECOMP_STATS_EN
    chk("zero_fill", zero_fill_count, 32);
`endif

    // Reset while a packet is held and fmt_err is set
    clear_q();
    global_buffer_req = 1'b0;
    do_start(4);
    push_block(8'h3F, 8'h31, 6);
    send_stream();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst2_pvalid_pre", pkt.packet_valid, 1);
    chk("rst2_fmt_pre", fmt_err, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    global_buffer_req = 1'b1;
    @(negedge clk);
    chk("rst2_pvalid", pkt.packet_valid, 0);
    chk("rst2_ack", decompressor_ack, 0);
    chk("rst2_ready", cmp_ready, 0);
    chk("rst2_done", done, 0);
    chk("rst2_fmt", fmt_err, 0);
`ifdef IFMAP_DECOMP_STATS_EN
    chk("rst2_stall", stall_count, 0);
    chk("rst2_zf", zero_fill_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
